// File: rtl/cache_dma_pkg.sv
// Shared types and helpers for the cache DMA scheduler: block geometry,
// FSM state encoding and block-address arithmetic.
package cache_dma_pkg;

    localparam int ADDR_W     = 32;
    localparam int BLOCK_BITS = 512;
    localparam int OFF        = $clog2(BLOCK_BITS / 8);

    typedef logic [ADDR_W-1:0]     addr_t;
    typedef logic [BLOCK_BITS-1:0] block_t;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RD_WAIT,
        DONE
    } state_e;

    // Two addresses refer to the same memory block when their tags match.
    function automatic logic same_block(input addr_t a, input addr_t b);
        return a[ADDR_W-1:OFF] == b[ADDR_W-1:OFF];
    endfunction

    function automatic addr_t block_align(input addr_t a);
        return {a[ADDR_W-1:OFF], {OFF{1'b0}}};
    endfunction

endpackage

// File: rtl/dma_wait_timer.sv
// Counts memory wait cycles for the current operation and raises a sticky
// flag once the count reaches TIMEOUT; only reset clears the flag.
module dma_wait_timer #(
    parameter int TIMEOUT = 1023
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic flag_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             flag_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != CNT_W'(TIMEOUT))) begin
            // Saturates at TIMEOUT so a very long stall cannot wrap the count.
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                flag_q <= 1'b1;
            end
        end
    end

    assign flag_o = flag_q;

endmodule

// File: rtl/cache_dma_scheduler.sv
// Serializes block refills and dirty write-backs onto one block-wide memory
// port, one operation at a time, with bounded write-back priority.
module cache_dma_scheduler
    import cache_dma_pkg::*;
#(
    parameter int MAX_EVICT_RUN = 4,
    parameter int TIMEOUT       = 1023
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   req_i,
    input  addr_t  req_addr_i,
    output logic   req_valid_o,
    output addr_t  req_addr_o,
    output block_t req_data_o,
    input  logic   evict_i,
    input  addr_t  evict_addr_i,
    input  block_t evict_data_i,
    output logic   evict_ack_o,
    output logic   mem_req_o,
    output logic   mem_we_o,
    output addr_t  mem_addr_o,
    output block_t mem_wdata_o,
    input  logic   mem_gnt_i,
    input  logic   mem_rvalid_i,
    input  block_t mem_rdata_i,
    output logic   busy_o,
    output logic   timeout_o
);

    localparam int RUN_W = $clog2(MAX_EVICT_RUN + 1);

    state_e           state_q;
    logic [RUN_W-1:0] run_q, run_d;
    logic             mem_req_q, mem_we_q;
    addr_t            mem_addr_q, req_addr_q;
    block_t           mem_wdata_q, req_data_q;
    logic             ev_ack_q, req_valid_q, busy_q;
    logic             pick_wr, pick_rd;
    logic             tmr_clr, tmr_en;

    // A write-back to the block being refilled must land first, so it wins
    // even when the run limit has been reached.
    always_comb begin
        pick_wr = evict_i && ((req_i && same_block(evict_addr_i, req_addr_i)) ||
                              !req_i || (run_q < RUN_W'(MAX_EVICT_RUN)));
        pick_rd = req_i && !pick_wr;
        run_d   = run_q;
        if (pick_wr) begin
            if (!req_i) begin
                run_d = '0;
            end else if (run_q != RUN_W'(MAX_EVICT_RUN)) begin
                run_d = run_q + 1'b1;
            end
        end else if (pick_rd) begin
            run_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            run_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ev_ack_q    <= 1'b0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            ev_ack_q    <= 1'b0;
            req_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    run_q <= run_d;
                    if (pick_wr) begin
                        state_q     <= WR;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= block_align(evict_addr_i);
                        mem_wdata_q <= evict_data_i;
                        busy_q      <= 1'b1;
                    end else if (pick_rd) begin
                        state_q    <= RD;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= block_align(req_addr_i);
                        busy_q     <= 1'b1;
                    end
                end
                WR: begin
                    if (mem_gnt_i) begin
                        mem_req_q <= 1'b0;
                        ev_ack_q  <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                RD: begin
                    if (mem_gnt_i) begin
                        mem_req_q <= 1'b0;
                        state_q   <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (mem_rvalid_i) begin
                        req_valid_q <= 1'b1;
                        req_data_q  <= mem_rdata_i;
                        req_addr_q  <= mem_addr_q;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    // Gives the requester one cycle to drop its level.
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tmr_clr = (state_q == IDLE) && (pick_wr || pick_rd);
    assign tmr_en  = (state_q == WR) || (state_q == RD) || (state_q == RD_WAIT);

    dma_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_timer (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (tmr_clr),
        .en_i  (tmr_en),
        .flag_o(timeout_o)
    );

    assign req_valid_o = req_valid_q;
    assign req_addr_o  = req_addr_q;
    assign req_data_o  = req_data_q;
    assign evict_ack_o = ev_ack_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_cache_dma_scheduler.sv
// Bench for cache_dma_scheduler: memory model, requester drivers, and an
// arbitration model that predicts every memory command from requester levels.
module tb_cache_dma_scheduler;
    import cache_dma_pkg::*;

    localparam int MAX_RUN = 4;
    localparam int TMO     = 1023;

    logic   clk = 1'b0;
    logic   rst_i = 1'b1;
    logic   req_i = 1'b0;
    addr_t  req_addr_i = '0;
    logic   req_valid_o;
    addr_t  req_addr_o;
    block_t req_data_o;
    logic   evict_i = 1'b0;
    addr_t  evict_addr_i = '0;
    block_t evict_data_i = '0;
    logic   evict_ack_o;
    logic   mem_req_o, mem_we_o;
    addr_t  mem_addr_o;
    block_t mem_wdata_o;
    logic   mem_gnt_i = 1'b0;
    logic   mem_rvalid_i = 1'b0;
    block_t mem_rdata_i = '0;
    logic   busy_o, timeout_o;

    always #5 clk = ~clk;

    cache_dma_scheduler #(.MAX_EVICT_RUN(MAX_RUN), .TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_i(req_i), .req_addr_i(req_addr_i),
        .req_valid_o(req_valid_o), .req_addr_o(req_addr_o), .req_data_o(req_data_o),
        .evict_i(evict_i), .evict_addr_i(evict_addr_i), .evict_data_i(evict_data_i),
        .evict_ack_o(evict_ack_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .busy_o(busy_o), .timeout_o(timeout_o)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [BLOCK_BITS-1:0] got,
                            input logic [BLOCK_BITS-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic addr_t align(input addr_t a);
        return a & ~addr_t'((1 << OFF) - 1);
    endfunction

    function automatic block_t rand_block();
        block_t b;
        for (int i = 0; i < BLOCK_BITS / 32; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    // Memory model and scoreboard state
    block_t mem_arr [addr_t];
    logic [BLOCK_BITS-1:0] exp_q[$];
    addr_t exp_addr_q[$];
    int  gnt_dly = 0, rv_dly = 1;
    bit  gnt_block = 0, noise = 0, drop_rd = 0;
    int  req_age = 0, rd_cnt = 0;
    bit  rd_pend = 0;
    addr_t rd_addr;

    // Arbitration model state
    bit  s_rst, s_req, s_ev;
    addr_t s_raddr, s_eaddr;
    block_t s_edata;
    int  run_m = 0;
    bit  req_prev = 0, ack_due = 0, rv_due = 0;
    int  n_wr = 0, n_rd = 0, n_rv = 0, n_ack = 0, wr_at_rd = 0;

    function automatic block_t mem_read(input addr_t a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return {16{a ^ 32'h5A5A_0000}};
    endfunction

    always @(posedge clk) begin
        s_rst   = rst_i;
        s_req   = req_i;
        s_ev    = evict_i;
        s_raddr = req_addr_i;
        s_eaddr = evict_addr_i;
        s_edata = evict_data_i;
    end

    always @(negedge clk) begin
        if (s_rst) begin
            run_m = 0; ack_due = 0; rv_due = 0; req_prev = 0;
        end else begin
            if (evict_ack_o || ack_due) check_eq("evict_ack_pulse", evict_ack_o, ack_due);
            if (req_valid_o || rv_due) begin
                check_eq("req_valid_pulse", req_valid_o, rv_due);
                if (req_valid_o && rv_due) begin
                    check_eq("req_data", req_data_o, exp_q.pop_front());
                    check_eq("req_addr", req_addr_o, exp_addr_q.pop_front());
                end
            end
            if (req_valid_o) n_rv++;
            if (evict_ack_o) n_ack++;
            ack_due = 0;
            rv_due  = 0;
            // New command: predict it from the requester levels seen at the decision edge.
            if (mem_req_o && !req_prev) begin
                if (s_ev && s_req && ((s_eaddr >> OFF) == (s_raddr >> OFF))) begin
                    check_eq("cmd_we_same_blk", mem_we_o, 1'b1);
                    check_eq("cmd_addr_wr", mem_addr_o, align(s_eaddr));
                    check_eq("cmd_wdata", mem_wdata_o, s_edata);
                    run_m = (run_m < MAX_RUN) ? run_m + 1 : MAX_RUN;
                    n_wr++;
                end else if (s_ev && (!s_req || run_m < MAX_RUN)) begin
                    check_eq("cmd_we_evict", mem_we_o, 1'b1);
                    check_eq("cmd_addr_wr", mem_addr_o, align(s_eaddr));
                    check_eq("cmd_wdata", mem_wdata_o, s_edata);
                    run_m = s_req ? ((run_m < MAX_RUN) ? run_m + 1 : MAX_RUN) : 0;
                    n_wr++;
                end else if (s_req) begin
                    check_eq("cmd_we_refill", mem_we_o, 1'b0);
                    check_eq("cmd_addr_rd", mem_addr_o, align(s_raddr));
                    exp_addr_q.push_back(align(s_raddr));
                    run_m = 0;
                    wr_at_rd = n_wr;
                    n_rd++;
                end else begin
                    check_eq("cmd_spurious", mem_req_o, 1'b0);
                end
            end
            req_prev = mem_req_o;
        end

        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        if (!mem_req_o) req_age = 0;
        if (rd_pend) begin
            if (rd_cnt == 0) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = mem_read(rd_addr);
                rd_pend      = 0;
                if (drop_rd) begin
                    drop_rd = 0;
                    void'(exp_addr_q.pop_front());
                end else begin
                    rv_due = 1;
                    exp_q.push_back(mem_rdata_i);
                end
            end else begin
                rd_cnt--;
            end
        end else if (mem_req_o) begin
            if (!gnt_block && req_age >= gnt_dly) begin
                mem_gnt_i = 1'b1;
                req_age   = 0;
                if (mem_we_o) begin
                    mem_arr[mem_addr_o] = mem_wdata_o;
                    ack_due = 1;
                end else begin
                    rd_pend = 1;
                    rd_cnt  = rv_dly - 1;
                    rd_addr = mem_addr_o;
                end
            end else begin
                req_age++;
            end
        end else if (noise) begin
            mem_gnt_i    = ($urandom_range(0, 3) == 0);
            mem_rvalid_i = ($urandom_range(0, 3) == 0);
            mem_rdata_i  = rand_block();
        end
    end

    task automatic refill(input addr_t a, input int bound, output int lat);
        req_i = 1'b1;
        req_addr_i = a;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!req_valid_o && lat < bound);
        check_eq("refill_complete", req_valid_o, 1'b1);
        req_i = 1'b0;
    endtask

    task automatic evict(input addr_t a, input block_t d, input int bound, output int lat);
        evict_i = 1'b1;
        evict_addr_i = a;
        evict_data_i = d;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!evict_ack_o && lat < bound);
        check_eq("evict_complete", evict_ack_o, 1'b1);
        evict_i = 1'b0;
    endtask

    // Keeps evict_i high across back-to-back write-backs, new block each time.
    task automatic evict_stream(input int n, input addr_t base);
        int lat;
        evict_i = 1'b1;
        for (int k = 0; k < n; k++) begin
            evict_addr_i = base + addr_t'(k * 64);
            evict_data_i = rand_block();
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!evict_ack_o && lat < 200);
            check_eq("stream_ack", evict_ack_o, 1'b1);
        end
        evict_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"}, busy_o, 1'b0);
        check_eq({tag, "_mem_req"}, mem_req_o, 1'b0);
        check_eq({tag, "_mem_we"}, mem_we_o, 1'b0);
        check_eq({tag, "_mem_addr"}, mem_addr_o, '0);
        check_eq({tag, "_mem_wdata"}, mem_wdata_o, '0);
        check_eq({tag, "_ack"}, evict_ack_o, 1'b0);
        check_eq({tag, "_rvalid"}, req_valid_o, 1'b0);
        check_eq({tag, "_req_addr"}, req_addr_o, '0);
        check_eq({tag, "_req_data"}, req_data_o, '0);
        check_eq({tag, "_timeout"}, timeout_o, 1'b0);
    endtask

    initial begin
        #500_000;
        checks++;
        failures++;
        $display("FAIL watchdog got=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int lat, lat2, w0, rv0, mode, skew;
        block_t pat_a, pat_b, pat_d;
        addr_t ra, ea;

        // Clock/reset
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        check_all_zero("reset");

        // Refill only: grant one cycle after request, rvalid three cycles later.
        pat_a = rand_block();
        mem_arr[32'h0000_1200] = pat_a;
        gnt_dly = 1; rv_dly = 3;
        refill(32'h0000_1234, 100, lat);
        check_eq("refill_latency", lat, 6);
        check_eq("refill_mem_addr", mem_addr_o, 32'h0000_1200);
        check_eq("refill_mem_we", mem_we_o, 1'b0);
        check_eq("refill_req_addr", req_addr_o, 32'h0000_1200);
        check_eq("refill_data", req_data_o, pat_a);
        check_eq("refill_busy_done", busy_o, 1'b1);
        @(negedge clk);
        check_eq("refill_busy_idle", busy_o, 1'b0);

        // Write-back only, same-cycle grant.
        pat_b = rand_block();
        gnt_dly = 0;
        evict(32'h0000_2040, pat_b, 100, lat);
        check_eq("wb_latency", lat, 2);
        check_eq("wb_mem_we", mem_we_o, 1'b1);
        check_eq("wb_mem_addr", mem_addr_o, 32'h0000_2040);
        check_eq("wb_wdata", mem_wdata_o, pat_b);
        check_eq("wb_busy_done", busy_o, 1'b1);
        @(negedge clk);
        check_eq("wb_busy_idle", busy_o, 1'b0);

        // Same block: the write must land before the read returns it.
        pat_d = rand_block();
        gnt_dly = 1; rv_dly = 2;
        fork
            evict(32'h0000_3000, pat_d, 100, lat);
            refill(32'h0000_3010, 100, lat2);
        join
        check_eq("same_blk_rdata", req_data_o, pat_d);
        check_eq("same_blk_order", lat < lat2, 1'b1);
        repeat (2) @(negedge clk);

        // Starvation bound: four write-backs, then the waiting refill.
        gnt_dly = 0; rv_dly = 1;
        w0 = n_wr;
        fork
            evict_stream(7, 32'h0000_9000);
            refill(32'h0000_8000, 200, lat);
        join
        check_eq("starve_writes_before_read", wr_at_rd - w0, MAX_RUN);
        check_eq("starve_total_writes", n_wr - w0, 7);
        repeat (2) @(negedge clk);

        // Timeout: withhold the grant past TIMEOUT, then complete normally.
        gnt_block = 1; rv_dly = 2;
        fork
            refill(32'h0000_4440, 3000, lat);
            begin
                int k = 0;
                do begin
                    @(negedge clk);
                    k++;
                end while (!mem_req_o && k < 10);
                check_eq("tmo_req_seen", mem_req_o, 1'b1);
                repeat (TMO - 1) @(negedge clk);
                check_eq("tmo_before", timeout_o, 1'b0);
                @(negedge clk);
                check_eq("tmo_at", timeout_o, 1'b1);
                repeat (1100 - TMO) @(negedge clk);
                check_eq("tmo_held", timeout_o, 1'b1);
                gnt_block = 0;
            end
        join
        check_eq("tmo_sticky_after", timeout_o, 1'b1);
        check_eq("tmo_refill_addr", req_addr_o, 32'h0000_4440);
        repeat (2) @(negedge clk);

        // Reset while waiting for read data.
        gnt_dly = 0; rv_dly = 20;
        req_i = 1'b1;
        req_addr_i = 32'h0000_5500;
        repeat (3) @(negedge clk);
        check_eq("rst_mid_busy", busy_o, 1'b1);
        drop_rd = 1;
        rst_i = 1'b1;
        req_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b0;
        check_all_zero("rst_mid");
        rv0 = n_rv;
        repeat (25) @(negedge clk);
        check_eq("rst_mid_no_valid", n_rv - rv0, 0);
        check_eq("rst_mid_idle", busy_o, 1'b0);

        // Random traffic with spurious grant/rvalid noise while idle.
        noise = 1;
        for (int it = 0; it < 40; it++) begin
            gnt_dly = $urandom_range(0, 2);
            rv_dly  = $urandom_range(1, 3);
            mode    = $urandom_range(0, 2);
            ra = 32'h0000_A000 + addr_t'($urandom_range(0, 7) * 64) + addr_t'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1)
                ea = align(ra) + addr_t'($urandom_range(0, 63));
            else
                ea = 32'h0000_A000 + addr_t'($urandom_range(0, 7) * 64) + addr_t'($urandom_range(0, 63));
            skew = $urandom_range(0, 2);
            if (mode == 0) begin
                refill(ra, 100, lat);
            end else if (mode == 1) begin
                evict(ea, rand_block(), 100, lat);
            end else begin
                fork
                    begin
                        repeat (skew) @(negedge clk);
                        refill(ra, 100, lat);
                    end
                    evict(ea, rand_block(), 100, lat2);
                join
            end
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        noise = 0;
        repeat (4) @(negedge clk);
        check_eq("final_idle", busy_o, 1'b0);
        check_eq("final_scoreboard_empty", exp_addr_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
